// File: rtl/ex_func_unit_if.sv
// ex_func_unit_if: issue/result handshake bundle for the execute-stage
// functional unit.
//   in_valid_i / in_ready_o   : operation handshake (upstream -> unit)
//   alu_op_i, fu_sel_i        : 4-bit ALU code, 2-bit result select
//   src1_i, src2_i, shamt_i   : operands and shift amount
//   sft_left_i                : 1 = logical left shift, 0 = logical right
//   out_valid_o / out_ready_i : result handshake (unit -> downstream)
//   result_o, zero_o, ovf_o   : registered result and flags
// Modports: master = pipeline side driving operations, slave = the unit.
interface ex_func_unit_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [3:0]         alu_op_i;
    logic [1:0]         fu_sel_i;
    logic [DATA_W-1:0]  src1_i;
    logic [DATA_W-1:0]  src2_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               sft_left_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  result_o;
    logic               zero_o;
    logic               ovf_o;

    modport master (
        output in_valid_i, alu_op_i, fu_sel_i, src1_i, src2_i, shamt_i,
               sft_left_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, ovf_o
    );

    modport slave (
        input  in_valid_i, alu_op_i, fu_sel_i, src1_i, src2_i, shamt_i,
               sft_left_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, ovf_o
    );
endinterface

// File: rtl/ex_func_unit.sv
// ex_func_unit: execute-stage functional unit. ALU and upper-immediate ops
// complete in one cycle; logical shifts use an iterative one-bit-per-cycle
// shifter. Result, zero and overflow flags are registered.
// Ports:
//   clk_i  : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ex_func_unit_if.slave (issue and result handshakes, operands)
// Build option: define FAST_SHIFT_EN to replace the iterative shifter with a
// single-cycle barrel shifter (same results, latency 1).
module ex_func_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_n,
    ex_func_unit_if.slave bus
);
    localparam int unsigned MSB  = DATA_W - 1;
    localparam int unsigned HALF = DATA_W / 2;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic               dir_q, dir_d;

    logic               out_valid_q;
    logic [DATA_W-1:0]  result_q;
    logic               zero_q;
    logic               ovf_q;

    logic               in_ready;
    logic               accept;
    logic [DATA_W-1:0]  sum, diff;
    logic [DATA_W-1:0]  alu_res, sc_res;
    logic               alu_ovf, sc_ovf;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_ovf;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready_i);
    assign accept   = bus.in_valid_i && in_ready;

    assign sum  = bus.src1_i + bus.src2_i;
    assign diff = bus.src1_i - bus.src2_i;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_op_i)
            4'b0000: alu_res = bus.src1_i & bus.src2_i;
            4'b0001: alu_res = bus.src1_i | bus.src2_i;
            4'b0010: begin
                alu_res = sum;
                // Like-signed operands producing an opposite-signed sum.
                alu_ovf = (bus.src1_i[MSB] == bus.src2_i[MSB]) &&
                          (sum[MSB] != bus.src1_i[MSB]);
            end
            4'b0110, 4'b0011: begin
                alu_res = diff;
                // Unlike-signed operands where the sign flips away from A.
                alu_ovf = (bus.src1_i[MSB] != bus.src2_i[MSB]) &&
                          (diff[MSB] != bus.src1_i[MSB]);
            end
            4'b0111: alu_res = {{(DATA_W-1){1'b0}},
                                ($signed(bus.src1_i) < $signed(bus.src2_i))};
            4'b1110: alu_res = ~(bus.src1_i | bus.src2_i);
            default: alu_res = '0;
        endcase
    end

    // Results of every operation that completes on its accept edge.
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (bus.fu_sel_i)
            2'd0: begin
                sc_res = alu_res;
                sc_ovf = alu_ovf;
            end
`ifdef FAST_SHIFT_EN
            2'd1: sc_res = bus.sft_left_i ? (bus.src2_i << bus.shamt_i)
                                          : (bus.src2_i >> bus.shamt_i);
`endif
            2'd2: sc_res = {bus.src2_i[HALF-1:0], {HALF{1'b0}}};
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        dir_d   = dir_q;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_ovf  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef FAST_SHIFT_EN
                    wr_en   = 1'b1;
                    wr_data = sc_res;
                    wr_ovf  = sc_ovf;
`else
                    if (bus.fu_sel_i == 2'd1) begin
                        state_d = SHIFT;
                        work_d  = bus.src2_i;
                        cnt_d   = bus.shamt_i;
                        dir_d   = bus.sft_left_i;
                    end else begin
                        wr_en   = 1'b1;
                        wr_data = sc_res;
                        wr_ovf  = sc_ovf;
                    end
`endif
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = dir_q ? (work_q << 1) : (work_q >> 1);
                    cnt_d  = cnt_q - SHAMT_W'(1);
                end else if (!out_valid_q || bus.out_ready_i) begin
                    // A finished shift waits here while the output is blocked.
                    wr_en   = 1'b1;
                    wr_data = work_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            dir_q   <= dir_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
        end else if (wr_en) begin
            out_valid_q <= 1'b1;
            result_q    <= wr_data;
            zero_q      <= (wr_data == '0);
            ovf_q       <= wr_ovf;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.zero_o      = zero_q;
    assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_ex_func_unit.sv
// Self-checking bench for ex_func_unit: expected results are queued on each
// accepted operation and compared when the unit hands a result over.
module tb_ex_func_unit;
    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cyc = 0;
    int   last_out_cyc = 0;
    int   busy_cnt = 0;
    bit   rand_stall = 1'b0;
    exp_t sb[$];
    int   out_cycs[$];

    ex_func_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

    ex_func_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [1:0] sel,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh, input logic left);
        exp_t e;
        logic [32:0] w;
        e.res = 32'h0;
        e.ovf = 1'b0;
        w = 33'h0;
        case (sel)
            2'd0: case (op)
                4'd0: e.res = a & b;
                4'd1: e.res = a | b;
                4'd2: begin
                    w = {a[31], a} + {b[31], b};
                    e.res = w[31:0];
                    e.ovf = w[32] ^ w[31];
                end
                4'd3, 4'd6: begin
                    w = {a[31], a} - {b[31], b};
                    e.res = w[31:0];
                    e.ovf = w[32] ^ w[31];
                end
                4'd7:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd14: e.res = ~(a | b);
                default: e.res = 32'h0;
            endcase
            2'd1: e.res = left ? (b << sh) : (b >> sh);
            2'd2: e.res = {b[15:0], 16'h0000};
            default: e.res = 32'h0;
        endcase
        return e;
    endfunction

    function automatic int shift_lat(input int sh);
`ifdef FAST_SHIFT_EN
        return 1;
`else
        return sh + 2;
`endif
    endfunction

    function automatic int shift_busy(input int sh);
`ifdef FAST_SHIFT_EN
        return 0;
`else
        return sh + 1;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic left);
        bit accepted = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.alu_op_i   = op;
        bus.fu_sel_i   = sel;
        bus.src1_i     = a;
        bus.src2_i     = b;
        bus.shamt_i    = sh;
        bus.sft_left_i = left;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk_i);
            if (bus.in_ready_o) begin
                sb.push_back(model(op, sel, a, b, sh, left));
                accepted = 1'b1;
            end
        end
        if (!accepted) begin
            check("accept_timeout", 32'(bus.in_ready_o), 32'd1);
            bus.in_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            acc_cyc = cyc;
            bus.in_valid_i = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag, input int exp_lat);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk_i);
        #1;
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end else if (exp_lat > 0) begin
            check({tag, "_latency"}, 32'(last_out_cyc - acc_cyc + 1), 32'(exp_lat));
        end
    endtask

    // Result monitor / scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n) begin
                if (!bus.in_ready_o) busy_cnt++;
                if (bus.out_valid_o && bus.out_ready_i) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 32'(bus.out_valid_o), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("result", bus.result_o, e.res);
                        check("zero", 32'(bus.zero_o), 32'(e.res == 32'h0));
                        check("ovf", 32'(bus.ovf_o), 32'(e.ovf));
                    end
                    last_out_cyc = cyc;
                    out_cycs.push_back(cyc);
                end
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (rand_stall) bus.out_ready_i = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc[4];
        bus.in_valid_i  = 1'b0;
        bus.alu_op_i    = 4'd0;
        bus.fu_sel_i    = 2'd0;
        bus.src1_i      = 32'h0;
        bus.src2_i      = 32'h0;
        bus.shamt_i     = 5'd0;
        bus.sft_left_i  = 1'b0;
        bus.out_ready_i = 1'b1;

        // Reset values.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_result", bus.result_o, 32'h0);
        check("rst_zero", 32'(bus.zero_o), 32'd1);
        check("rst_ovf", 32'(bus.ovf_o), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;

        // Signed overflow on ADD.
        issue(4'b0010, 2'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0);
        wait_drain("add_ovf", 1);

        issue(4'b0110, 2'd0, 32'd5, 32'd5, 5'd0, 1'b0);
        wait_drain("sub_zero", 1);
        issue(4'b0111, 2'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        wait_drain("slt", 1);
        issue(4'b1110, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0);
        wait_drain("nor", 1);
        issue(4'b0011, 2'd0, 32'h8000_0000, 32'd1, 5'd0, 1'b0);
        wait_drain("sub_alt_ovf", 1);
        issue(4'b0101, 2'd0, 32'h1234_5678, 32'h1, 5'd0, 1'b0);
        wait_drain("undef_op", 1);
        issue(4'b0010, 2'd3, 32'h1, 32'h1, 5'd0, 1'b0);
        wait_drain("sel_reserved", 1);

        // Shifts: latency and busy cycles.
        busy_cnt = 0;
        issue(4'b0000, 2'd1, 32'h0, 32'h1, 5'd4, 1'b1);
        wait_drain("shl4", shift_lat(4));
        check("shl4_busy", 32'(busy_cnt), 32'(shift_busy(4)));
        busy_cnt = 0;
        issue(4'b0000, 2'd1, 32'h0, 32'h8000_0000, 5'd31, 1'b0);
        wait_drain("shr31", shift_lat(31));
        check("shr31_busy", 32'(busy_cnt), 32'(shift_busy(31)));
        issue(4'b0000, 2'd1, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1);
        wait_drain("sh0", shift_lat(0));

        // Upper immediate with back-pressure.
        bus.out_ready_i = 1'b0;
        issue(4'b0000, 2'd2, 32'h0, 32'h0000_ABCD, 5'd0, 1'b0);
        repeat (3) begin
            @(negedge clk_i);
            check("hold_valid", 32'(bus.out_valid_o), 32'd1);
            check("hold_result", bus.result_o, 32'hABCD_0000);
            check("hold_in_ready", 32'(bus.in_ready_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        bus.out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("release_valid", 32'(bus.out_valid_o), 32'd0);
        check("release_drained", 32'(sb.size()), 32'd0);

        // Back-to-back throughput.
        out_cycs.delete();
        for (int i = 0; i < 4; i++) begin
            issue(4'b0010, 2'd0, 32'(i * 100), 32'(i + 7), 5'd0, 1'b0);
            acc[i] = acc_cyc;
        end
        wait_drain("burst", 1);
        check("burst_count", 32'(out_cycs.size()), 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("burst_accept_gap", 32'(acc[i+1] - acc[i]), 32'd1);
            if (out_cycs.size() == 4)
                check("burst_out_gap", 32'(out_cycs[i+1] - out_cycs[i]), 32'd1);
        end

        // Randomised mix with random output stalls.
        rand_stall = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [1:0] sel;
            op  = 4'($urandom_range(0, 15));
            sel = 2'($urandom_range(0, 3));
            issue(op, sel, $urandom, $urandom, 5'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
        end
        rand_stall = 1'b0;
        #1;
        bus.out_ready_i = 1'b1;
        wait_drain("random", 0);

        // Reset while a shift is in progress.
        issue(4'b0000, 2'd1, 32'h0, 32'h0000_00F0, 5'd3, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid_o), 32'd0);
        check("midrst_result", bus.result_o, 32'h0);
        check("midrst_zero", 32'(bus.zero_o), 32'd1);
        sb.delete();
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        check("midrst_in_ready", 32'(bus.in_ready_o), 32'd1);
        repeat (10) @(posedge clk_i);
        #1;
        check("midrst_no_stale", 32'(bus.out_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_func_unit.md
Name: ex_func_unit

Overview:
- Execute-stage functional unit that sits directly downstream of the ALU control stage.
- Consumes the 4-bit ALU operation code and 2-bit functional-unit result select, plus operands, and produces the registered write-back result with zero/overflow flags.
- ALU ops and immediate-upper ops complete in one cycle; shifts run on an iterative one-bit-per-cycle shifter.
- Valid/ready handshake on both sides, so the pipeline stalls during multi-cycle shifts.

Parameters:
- DATA_W, 32, operand/result width (even, >= 8)
- SHAMT_W, 5, shift-amount width; DATA_W == 2**SHAMT_W

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  operation presented
- in_ready_o  out  1  unit can accept this cycle
- alu_op_i  in  4  ALU operation code
- fu_sel_i  in  2  result select: 0 ALU, 1 shifter, 2 upper-immediate, 3 reserved
- src1_i  in  DATA_W  operand A (rs)
- src2_i  in  DATA_W  operand B (rt / immediate)
- shamt_i  in  SHAMT_W  shift amount
- sft_left_i  in  1  1 = logical left, 0 = logical right
- out_valid_o  out  1  result register holds valid data
- out_ready_i  in  1  consumer takes result this cycle
- result_o  out  DATA_W  registered result
- zero_o  out  1  result_o == 0, registered with result
- ovf_o  out  1  signed overflow of ADD/SUB, else 0

Behaviour:
- Reset:
  - Asynchronous on rst_n low; state IDLE, counter 0.
  - out_valid_o=0, result_o=0, zero_o=1, ovf_o=0.
  - Reset mid-shift abandons the operation and emits no result.
- Handshake:
  - Accept edge = rising edge with in_valid_i && in_ready_o.
  - in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i).
  - out_valid_o clears on an edge where out_ready_i=1 unless a new result is written on that same edge.
  - result_o/zero_o/ovf_o hold stable while out_valid_o && !out_ready_i.
- ALU codes (fu_sel_i=0):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 SUB.
  - 0111 SLT: signed, result 1 or 0.
  - 1110 NOR.
  - Any other code gives result 0.
  - Arithmetic wraps mod 2**DATA_W.
  - ovf_o = signed overflow for ADD/SUB codes only.
- fu_sel_i=2: result = src2_i[DATA_W/2-1:0] followed by DATA_W/2 zero bits.
- fu_sel_i=3: result 0, single-cycle.
- Single-cycle ops (fu_sel 0/2/3): result written on the accept edge; out_valid_o=1 the following cycle (latency 1).
- Shift FSM, states IDLE, SHIFT:
  - IDLE->SHIFT on accept with fu_sel_i=1: work <= src2_i, cnt <= shamt_i, direction latched.
  - In SHIFT, each edge with cnt!=0: work shifted by 1 in the latched direction, zero fill; cnt decrements.
  - In SHIFT, edge with cnt==0 and (!out_valid_o || out_ready_i): write work to result, go to IDLE.
  - If the output is blocked, stay in SHIFT with cnt==0.
  - Shift latency (accept to out_valid_o) = shamt_i+2 cycles; shamt_i=0 takes 2 cycles and returns src2_i unchanged.
  - in_ready_o=0 throughout SHIFT.
- Back-to-back operation: a single-cycle op can be accepted every cycle while out_ready_i=1.
- zero_o is always recomputed from the written result.

Optional Feature:
- FAST_SHIFT_EN defined: shifts use a combinational barrel shifter, are single-cycle (latency 1, identical to ALU ops), and SHIFT state is never entered.
- Undefined: iterative shifter as described above.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Reset while in SHIFT with cnt=3 -> immediately out_valid_o=0, result_o=0, zero_o=1; after release in_ready_o=1 and no stale result emitted.
- ADD 0x7FFFFFFF+1 (alu_op 0010, fu_sel 0), out_ready_i=1 -> next cycle out_valid_o=1, result 0x80000000, ovf_o=1, zero_o=0.
- SUB 5-5 (0110) -> result 0, zero_o=1; then SLT -1,1 (0111) -> result 1; NOR 0,0 (1110) -> 0xFFFFFFFF.
- Shift left src2=0x00000001, shamt=4 -> in_ready_o=0 for the busy cycles; out_valid_o rises 6 cycles after accept with result 0x00000010. Right shift 0x80000000 by 31 -> 0x00000001.
- Upper-immediate src2=0x0000ABCD, fu_sel 2 -> result 0xABCD0000. Hold out_ready_i=0 for 3 cycles -> result stable, in_ready_o=0; release -> out_valid_o drops the next cycle.
- Throughput: 4 consecutive ADDs with in_valid_i and out_ready_i held high -> 4 results on 4 consecutive cycles. With FAST_SHIFT_EN, shift shamt=31 also has latency 1.
